uart_tx_frame: RTL

//  Serialises one DATA_WIDTH-bit word into a UART frame on TX_OUT: start(0), data LSB-first,

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_bit_timer.sv | 44 ++++
 rtl/uart_tx_frame.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and the parity-type
// encoding also used when the receiver decodes its config.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_PARITY_EVEN = 1'b0;
    localparam logic UART_PARITY_ODD  = 1'b1;

    // A prescale of zero would never finish a bit, so it runs at one clock per bit.
    function automatic logic [7:0] eff_prescale(input logic [7:0] p);
        return (p == 8'd0) ? 8'd1 : p;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter: counts clocks within a bit
// and tracks which data bit is being sent.
module uart_tx_bit_timer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            clear,
    input  logic            active,
    input  logic            data_phase,
    input  logic [7:0]      prescale,
    output logic            bit_done,
    output logic            last_data_bit,
    output logic [IDXW-1:0] bit_idx
);

    logic [7:0]      cnt_q;
    logic [IDXW-1:0] idx_q;

    assign bit_done      = active && (cnt_q == prescale - 8'd1);
    assign last_data_bit = (idx_q == IDXW'(DATA_WIDTH - 1));
    assign bit_idx       = idx_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= 8'd0;
            idx_q <= '0;
        end else if (clear) begin
            cnt_q <= 8'd0;
            idx_q <= '0;
        end else if (bit_done) begin
            cnt_q <= 8'd0;
            if (data_phase) begin
                idx_q <= last_data_bit ? '0 : idx_q + IDXW'(1);
            end
        end else if (active) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one word as start, data LSB-first,
// optional parity and stop, with a busy/valid handshake upstream.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic [7:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic [7:0]            ps_q;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;

    logic            accept;
    logic            active;
    logic            bit_done;
    logic            last_data_bit;
    logic [IDXW-1:0] bit_idx;
    logic [IDXW-1:0] idx_n;
    logic            par_bit;

    assign accept = (state_q == ST_IDLE) && Data_Valid;
    assign active = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

    assign par_bit = (^data_q) ^ (par_type_q == UART_PARITY_ODD);

    // Index of the data bit on the line next cycle.
    assign idx_n = (state_q == ST_DATA && bit_done) ?
                   bit_idx + IDXW'(1) : bit_idx;

    uart_tx_bit_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDXW       (IDXW)
    ) u_timer (
        .CLK           (CLK),
        .RST           (RST),
        .clear         (accept),
        .active        (active),
        .data_phase    (state_q == ST_DATA),
        .prescale      (ps_q),
        .bit_done      (bit_done),
        .last_data_bit (last_data_bit),
        .bit_idx       (bit_idx)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Data_Valid) state_d = ST_START;
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done && last_data_bit) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_done) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level is registered from the state being entered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != ST_IDLE);
        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[idx_n];
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            ps_q       <= 8'd0;
        end else if (accept) begin
            data_q     <= P_DATA;
            par_en_q   <= parity_enable;
            par_type_q <= parity_type;
            ps_q       <= eff_prescale(Prescale);
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule
